axis_packet_source: RTL and testbench

- Parametrised successor to the single-beat byte-to-AXI-Stream source.
- Accepts narrow input units (default 8-bit) under a valid/ready handshake and packs them little-endian into DATA_W-bit AXI-Stream beats.
- Frames packets of a programmable length, generating tlast and tkeep, and buffers beats in a FIFO so that downstream tready stalls never lose data.
- Sits between peripheral/capture logic and the SoC streaming data path.

---
 rtl/params_pkg.sv | 19 +
 rtl/axis_sync_fifo.sv | 65 ++++++
 rtl/axis_packet_source.sv | 149 ++++++++++++++
 tb/tb_axis_packet_source.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared streaming-path constants and types.
// Provides the packet-source FSM states and the FIFO beat layout.
package params_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_IN_W   = 8;

    typedef enum logic {
        IDLE,
        RUN
    } pkt_src_state_t;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0]   data;
        logic [AXIS_DATA_W/8-1:0] keep;
        logic                     last;
    } axis_beat_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through FIFO with registered read data and valid.
// Occupancy is tracked by extended pointers; a slot is freed only on pop.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full,
    output logic             nonempty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] rdata_q;
    logic             valid_q;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full_q;
    assign do_pop   = pop && valid_q;
    assign rdata    = rdata_q;
    assign valid    = valid_q;
    assign full     = full_q;
    assign nonempty = (wr_q != rd_q);

    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, do_push};
        rd_d = rd_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= wdata;
        end
    end

    // Output stage samples the pre-push write pointer, adding one cycle of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            valid_q <= (wr_q != rd_d);
            rdata_q <= (wr_q != rd_d) ? mem_q[rd_d[AW-1:0]] : '0;
            full_q  <= (wr_d[AW] != rd_d[AW]) &&
                       (wr_d[AW-1:0] == rd_d[AW-1:0]);
        end
    end

endmodule

// File: rtl/axis_packet_source.sv
// Packs narrow input units into framed AXI-Stream beats through a beat FIFO.
// Define AXIS_PKT_SRC_STATS_EN to add pkt_count/stall_cycles counters.
module axis_packet_source
    import params_pkg::*;
#(
    parameter int IN_W       = AXIS_IN_W,
    parameter int DATA_W     = AXIS_DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [LEN_W-1:0]    pkt_len,
    input  logic [IN_W-1:0]     data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [DATA_W-1:0]   m_tdata,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                m_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                busy
`ifdef AXIS_PKT_SRC_STATS_EN
    ,
    output logic [31:0]         pkt_count,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int LANES  = DATA_W / IN_W;
    localparam int KPL    = IN_W / 8;
    localparam int KEEP_W = DATA_W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    pkt_src_state_t    state_q;
    logic [LANE_W-1:0] lane_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DATA_W-1:0] pack_q;
    logic [DATA_W-1:0] pack_d;
    logic [KEEP_W-1:0] keep_d;

    logic       accept;
    logic       last_unit;
    logic       word_done;
    logic       fifo_full;
    logic       fifo_nonempty;
    axis_beat_t beat_d;
    axis_beat_t beat_o;

    assign data_ready = (state_q == RUN) && !fifo_full;
    assign accept     = data_valid && data_ready;
    assign last_unit  = (rem_q == LEN_W'(1));
    assign word_done  = (lane_q == LANE_W'(LANES - 1)) || last_unit;
    assign busy       = (state_q == RUN) || fifo_nonempty;

    // Lanes above the current one are already zero because pack_q clears on push.
    always_comb begin
        pack_d = pack_q;
        pack_d[int'(lane_q) * IN_W +: IN_W] = data_in;
        keep_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i <= int'(lane_q)) begin
                keep_d[i * KPL +: KPL] = '1;
            end
        end
        beat_d.data = pack_d;
        beat_d.keep = keep_d;
        beat_d.last = last_unit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            rem_q   <= '0;
            pack_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable && (pkt_len != '0)) begin
                        state_q <= RUN;
                        rem_q   <= pkt_len;
                        lane_q  <= '0;
                        pack_q  <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (word_done) begin
                            lane_q <= '0;
                            pack_q <= '0;
                        end else begin
                            lane_q <= lane_q + LANE_W'(1);
                            pack_q <= pack_d;
                        end
                        if (last_unit) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_sync_fifo #(
        .WIDTH ($bits(axis_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (accept && word_done),
        .wdata    (beat_d),
        .pop      (m_tready),
        .rdata    (beat_o),
        .valid    (m_tvalid),
        .full     (fifo_full),
        .nonempty (fifo_nonempty)
    );

    assign m_tdata = beat_o.data;
    assign m_tkeep = beat_o.keep;
    assign m_tlast = beat_o.last;

`ifdef AXIS_PKT_SRC_STATS_EN
    logic [31:0] pkt_count_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count_q <= '0;
            stall_q     <= '0;
        end else begin
            if (m_tvalid && m_tready && m_tlast) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
            if (m_tvalid && !m_tready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign pkt_count    = pkt_count_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_axis_packet_source.sv
// Directed and randomized bench for axis_packet_source.
// A unit-list packet model feeds a beat scoreboard checked at each handshake.
module tb_axis_packet_source;

    localparam int IN_W   = 8;
    localparam int DATA_W = 32;
    localparam int LANES  = DATA_W / IN_W;
    localparam int KEEP_W = DATA_W / 8;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [LEN_W-1:0]  pkt_len = '0;
    logic [IN_W-1:0]   data_in = '0;
    logic              data_valid = 1'b0;
    logic              data_ready;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic              busy;
`ifdef AXIS_PKT_SRC_STATS_EN
    logic [31:0]       pkt_count;
    logic [31:0]       stall_cycles;
`endif

    axis_packet_source #(
        .IN_W       (IN_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .pkt_len      (pkt_len),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .m_tdata      (m_tdata),
        .m_tkeep      (m_tkeep),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .busy         (busy)
`ifdef AXIS_PKT_SRC_STATS_EN
        ,
        .pkt_count    (pkt_count),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef logic [7:0] uq_t[$];
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    int    beats_seen = 0;
    int    acc_cnt = 0;
    bit    rnd_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A packet of n units becomes ceil(n/LANES) beats, low unit in low byte.
    function automatic void model_pkt(input uq_t u);
        int    n;
        int    cnt;
        beat_t e;
        n = u.size();
        for (int b = 0; b * LANES < n; b++) begin
            cnt = n - b * LANES;
            if (cnt > LANES) cnt = LANES;
            e.data = '0;
            for (int k = 0; k < cnt; k++)
                e.data = e.data | (DATA_W'(u[b * LANES + k]) << (IN_W * k));
            e.keep = KEEP_W'((1 << (cnt * IN_W / 8)) - 1);
            e.last = (b * LANES + cnt == n);
            exp_q.push_back(e);
        end
    endfunction

    function automatic uq_t gen(input int n);
        uq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    beat_t             mon_e;
    bit                st_prev = 1'b0;
    logic [DATA_W-1:0] st_data;
    logic [KEEP_W-1:0] st_keep;
    logic              st_last;

    always @(negedge clk) begin
        if (!reset_n) begin
            st_prev = 1'b0;
        end else begin
            if (st_prev) begin
                check("stall_tvalid", m_tvalid, 1'b1);
                check("stall_beat", {m_tdata, m_tkeep, m_tlast},
                      {st_data, st_keep, st_last});
            end
            if (m_tvalid && m_tready) begin
                beats_seen++;
                check("beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("tdata", m_tdata, mon_e.data);
                    check("tkeep", m_tkeep, mon_e.keep);
                    check("tlast", m_tlast, mon_e.last);
                end
            end
            st_prev = m_tvalid && !m_tready;
            st_data = m_tdata;
            st_keep = m_tkeep;
            st_last = m_tlast;
        end
    end

    task automatic send_pkt(input uq_t u, input int vpct,
                            input int stop_after, input bit lat_chk);
        int idx;
        int guard;
        int since;
        idx = 0;
        guard = 0;
        since = -1;
        @(posedge clk); #1;
        enable = 1'b1;
        pkt_len = LEN_W'(u.size());
        @(posedge clk); #1;
        enable = 1'b0;
        while (idx < stop_after && guard < 4000) begin
            data_valid = ($urandom_range(99) < vpct);
            data_in = u[idx];
            if (rnd_rdy) m_tready = ($urandom_range(99) < 70);
            @(negedge clk);
            if (since >= 0) since++;
            if (lat_chk && since == 1) check("lat_edge1_tvalid", m_tvalid, 1'b0);
            if (lat_chk && since == 2) check("lat_edge2_tvalid", m_tvalid, 1'b1);
            if (data_valid && data_ready) begin
                idx++;
                acc_cnt++;
                if (idx == LANES) since = 0;
            end
            @(posedge clk); #1;
            guard++;
        end
        data_valid = 1'b0;
        check("send_done", idx, stop_after);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        m_tready = 1'b1;
        while ((exp_q.size() != 0 || busy) && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tvalid"}, m_tvalid, 1'b0);
        check({tag, "_tdata"}, m_tdata, 0);
        check({tag, "_tkeep"}, m_tkeep, 0);
        check({tag, "_tlast"}, m_tlast, 1'b0);
        check({tag, "_ready"}, data_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        uq_t u;
        int  b0;
        int  n;
        int  g;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_zero("post_reset");

        m_tready = 1'b1;
        u.delete();
        for (int i = 1; i <= 8; i++) u.push_back(8'(i));
        model_pkt(u);
        send_pkt(u, 100, 8, 1'b1);
        wait_drain();

        u.delete();
        for (int i = 0; i < 5; i++) u.push_back(8'hA1 + 8'(i));
        model_pkt(u);
        send_pkt(u, 100, 5, 1'b0);
        wait_drain();

        m_tready = 1'b0;
        u = gen(40);
        model_pkt(u);
        acc_cnt = 0;
        b0 = beats_seen;
        fork
            send_pkt(u, 100, 40, 1'b0);
            begin
                logic [DATA_W+KEEP_W:0] snap;
                int gb;
                gb = 0;
                do begin
                    @(posedge clk); #2;
                    gb++;
                end while ((data_ready || acc_cnt == 0) && gb < 500);
                check("bp_accepts", acc_cnt, DEPTH * LANES);
                check("bp_tvalid", m_tvalid, 1'b1);
                snap = {m_tdata, m_tkeep, m_tlast};
                repeat (6) begin
                    @(posedge clk); #2;
                    check("bp_ready_low", data_ready, 1'b0);
                end
                check("bp_stable", {m_tdata, m_tkeep, m_tlast}, snap);
                m_tready = 1'b1;
            end
        join
        wait_drain();
        check("bp_beats", beats_seen - b0, 40 / LANES);

        @(posedge clk); #1;
        enable = 1'b1;
        pkt_len = '0;
        data_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("len0_ready", data_ready, 1'b0);
            check("len0_busy", busy, 1'b0);
        end
        @(posedge clk); #1;
        enable = 1'b0;
        data_valid = 1'b0;

        u.delete();
        u.push_back(8'h5A);
        model_pkt(u);
        send_pkt(u, 100, 1, 1'b0);
        wait_drain();

        rnd_rdy = 1'b1;
        for (int p = 0; p < 15; p++) begin
            n = $urandom_range(23, 1);
            u = gen(n);
            model_pkt(u);
            send_pkt(u, $urandom_range(100, 40), n, 1'b0);
        end
        rnd_rdy = 1'b0;
        wait_drain();

        m_tready = 1'b0;
        u = gen(8);
        send_pkt(u, 100, 6, 1'b0);
        check("mid_tvalid", m_tvalid, 1'b1);
        check("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        b0 = beats_seen;
        m_tready = 1'b1;
        u = gen(4);
        model_pkt(u);
        send_pkt(u, 100, 4, 1'b0);
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        check("rst_one_beat", beats_seen - b0, 1);

`ifdef AXIS_PKT_SRC_STATS_EN
        reset_n = 1'b0;
        #1;
        check("stats_rst_pkt", pkt_count, 0);
        check("stats_rst_stall", stall_cycles, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_tready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            u = gen(4);
            model_pkt(u);
            send_pkt(u, 100, 4, 1'b0);
            wait_drain();
        end
        m_tready = 1'b0;
        u = gen(4);
        model_pkt(u);
        send_pkt(u, 100, 4, 1'b0);
        g = 0;
        while (!m_tvalid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("stats_tvalid", m_tvalid, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        m_tready = 1'b1;
        wait_drain();
        check("stats_pkt_count", pkt_count, 3);
        check("stats_stall", stall_cycles, 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
